mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Bus initiator for the native memory interface, i.e. the requesting end of the valid/ready bus served by the Memory block.
- Accepts one core-side load, store or fetch at a time, then drives the mem bus.
- Performs byte-lane steering, write-strobe generation and load sign/zero extension.
- Returns a single-cycle response to the core.

Parameters:
- ADDR_WIDTH, 16, width of io_req_addr and io_mem_addr (16 bits addresses 64 KiB).
- TIMEOUT_CYCLES, 255, bus wait limit in cycles; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- io_req_valid  in  1  core request present.
- io_req_ready  out  1  initiator can accept a request (high only in IDLE).
- io_req_instr  in  1  request is an instruction fetch.
- io_req_write  in  1  1 = store, 0 = load or fetch.
- io_req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- io_req_unsigned  in  1  zero-extend load data (default is sign-extend).
- io_req_addr  in  ADDR_WIDTH  byte address.
- io_req_wdata  in  32  store data, right-aligned.
- io_rsp_valid  out  1  one-cycle response pulse.
- io_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- io_rsp_error  out  1  misaligned access or bus timeout; qualified by io_rsp_valid.
- io_mem_valid  out  1  bus request.
- io_mem_instr  out  1  fetch flag.
- io_mem_wstrb  out  4  byte write enables; 0 for reads.
- io_mem_wdata  out  32  lane-steered store data.
- io_mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- io_mem_rdata  in  32  read data; valid when io_mem_ready is high.
- io_mem_ready  in  1  responder completes the transfer.

Behaviour:
- Reset state: FSM in IDLE. Outputs: io_req_ready=1; io_rsp_valid=0, io_rsp_rdata=0, io_rsp_error=0; io_mem_valid=0, io_mem_instr=0, io_mem_wstrb=0, io_mem_wdata=0, io_mem_addr=0.
- States are IDLE, BUS and RESP.
- IDLE:
  - A request is accepted when io_req_valid && io_req_ready.
  - Misaligned requests do not touch the bus and go to RESP with error=1. Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise, on the accept edge, register mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}, mem_instr, mem_wstrb and mem_wdata; set mem_valid=1; go to BUS.
- Store lane steering:
  - Byte: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 4'b0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'hF; wdata unchanged.
- BUS:
  - All io_mem_* outputs are held stable while waiting.
  - On io_mem_ready=1: capture rdata, clear mem_valid and mem_wstrb on the same edge, go to RESP.
  - io_mem_ready is sampled even in the first BUS cycle, so a zero-wait responder is supported.
- Load extraction:
  - Shift io_mem_rdata right by 8*addr[1:0].
  - Byte result is 8-bit extended; half result is 16-bit extended.
  - Sign-extend unless io_req_unsigned=1.
  - Fetches always return the full word.
- RESP: io_rsp_valid=1 for exactly one cycle, then IDLE. io_req_ready stays low in BUS and RESP.
- Latency: from the accept edge to io_rsp_valid is 2 cycles with a zero-wait responder, plus N cycles for N wait cycles. Misaligned requests take 1 cycle.
- io_mem_ready while in IDLE or RESP is ignored.
- Reset asserted in any state returns the FSM to IDLE on that edge and drops io_mem_valid. Any in-flight response is discarded and never signalled.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+ bit wait counter clears on entry to BUS and increments each BUS cycle.
  - When it reaches TIMEOUT_CYCLES without io_mem_ready, mem_valid is cleared and the FSM goes to RESP with rsp_error=1 and rdata=0.
- MEM_TIMEOUT_EN undefined: no counter; BUS waits indefinitely.

Decomposition:
- Shared package mem_bus_pkg holds:
  - size encodings SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2;
  - the FSM state enum;
  - the wstrb base masks.
- One sub-module, mem_lane_align, is natural. It is combinational and does both directions of lane handling: store steering (wstrb and wdata) and load extraction/extension. It is shared with any future data-port initiator.

Test Plan:
- Word fetch, addr 0x0010, responder 0-wait, rdata 0xDEADBEEF -> mem_addr=0x0010, instr=1, wstrb=0; rsp_valid 2 cycles after accept, rdata 0xDEADBEEF, error 0.
- Signed byte load, addr 0x0013, mem_rdata 0x80AABBCC -> mem_addr 0x0010; rsp_rdata 0xFFFFFF80. Same with unsigned=1 -> 0x00000080.
- Half store, addr 0x0022, wdata 0x1234ABCD -> wstrb 4'b1100, mem_wdata 0xABCDABCD; rsp_rdata 0.
- Misaligned word load at 0x0006 -> io_mem_valid never rises; rsp_valid with error=1 one cycle after accept.
- Responder holds ready low 5 cycles -> mem_* outputs stable all 5 cycles; response one cycle after ready; req_ready low throughout.
- Reset pulsed during BUS -> mem_valid 0 and FSM in IDLE after the edge, no rsp_valid. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready never asserted -> rsp_error=1 after 4 BUS cycles.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the native memory bus: access size encodings,
// the initiator FSM state type, base write-strobe masks and an alignment helper.
package mem_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Strobe patterns for lane 0; shifted left by the byte offset for narrow stores.
  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [3:0] WSTRB_HALF = 4'b0011;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  // Halves need an even address, words (size 2 or 3) a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane handling for a 32-bit data port.
// Store side: write-strobe and replicated write-data generation.
// Load side: right-align the addressed lanes and sign/zero extend.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  input  logic        instr_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Store steering: replicate narrow data across the word and place the strobes.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    wstrb_o = 4'b0000;
    wdata_o = wdata_i;
    case (size_i)
      SIZE_BYTE: begin
        wstrb_o = WSTRB_BYTE << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        wstrb_o = WSTRB_HALF << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: wstrb_o = WSTRB_WORD;
    endcase
    if (!write_i) begin
      wstrb_o = 4'b0000;
    end
  end

  // Load extraction: fetches return the raw word, loads are shifted and extended.
  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    rdata_o = rdata_i;
    if (!instr_i) begin
      case (size_i)
        SIZE_BYTE: rdata_o = {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]};
        SIZE_HALF: rdata_o = {{16{shifted[15] & ~unsigned_i}}, shifted[15:0]};
        default:   rdata_o = rdata_i;
      endcase
    end
  end

endmodule

// File: rtl/mem_initiator.sv
// Native memory bus initiator: accepts one core request at a time, runs it on
// the valid/ready mem bus and returns a one-cycle response.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_initiator
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_req_valid,
  output logic                  io_req_ready,
  input  logic                  io_req_instr,
  input  logic                  io_req_write,
  input  logic [1:0]            io_req_size,
  input  logic                  io_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] io_req_addr,
  input  logic [31:0]           io_req_wdata,
  output logic                  io_rsp_valid,
  output logic [31:0]           io_rsp_rdata,
  output logic                  io_rsp_error,
  output logic                  io_mem_valid,
  output logic                  io_mem_instr,
  output logic [3:0]            io_mem_wstrb,
  output logic [31:0]           io_mem_wdata,
  output logic [ADDR_WIDTH-1:0] io_mem_addr,
  input  logic [31:0]           io_mem_rdata,
  input  logic                  io_mem_ready
);

  state_e                state_q, state_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_instr_q, mem_instr_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  uns_q, uns_d;
  logic                  write_q, write_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic [1:0]  align_size;
  logic [1:0]  align_off;
  logic [3:0]  align_wstrb;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // In IDLE the aligner steers the incoming store; afterwards it extracts the
  // load using the size and offset captured at accept.
  assign align_size = (state_q == ST_IDLE) ? io_req_size       : size_q;
  assign align_off  = (state_q == ST_IDLE) ? io_req_addr[1:0]  : off_q;

  mem_lane_align u_align (
    .size_i     (align_size),
    .addr_lo_i  (align_off),
    .write_i    (io_req_write),
    .wdata_i    (io_req_wdata),
    .wstrb_o    (align_wstrb),
    .wdata_o    (align_wdata),
    .instr_i    (mem_instr_q),
    .unsigned_i (uns_q),
    .rdata_i    (io_mem_rdata),
    .rdata_o    (align_rdata)
  );

  // Next-state and registered-output logic for the IDLE/BUS/RESP sequence.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_instr_d = mem_instr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_addr_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    write_d     = write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (io_req_valid) begin
          size_d  = io_req_size;
          off_d   = io_req_addr[1:0];
          uns_d   = io_req_unsigned;
          write_d = io_req_write;
          if (is_misaligned(io_req_size, io_req_addr[1:0])) begin
            rsp_error_d = 1'b1;
            rsp_rdata_d = 32'h0;
            state_d     = ST_RESP;
          end else begin
            mem_addr_d  = {io_req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_instr_d = io_req_instr;
            mem_wstrb_d = align_wstrb;
            mem_wdata_d = align_wdata;
            mem_valid_d = 1'b1;
            rsp_error_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_d  = '0;
`endif
            state_d     = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (io_mem_ready) begin
          mem_valid_d = 1'b0;
          mem_wstrb_d = 4'b0000;
          rsp_rdata_d = write_q ? 32'h0 : align_rdata;
          rsp_error_d = 1'b0;
          state_d     = ST_RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_valid_d = 1'b0;
          mem_wstrb_d = 4'b0000;
          rsp_rdata_d = 32'h0;
          rsp_error_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        rsp_rdata_d = 32'h0;
        rsp_error_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      mem_addr_q  <= '0;
      size_q      <= SIZE_BYTE;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      write_q     <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_instr_q <= mem_instr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      write_q     <= write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign io_req_ready = (state_q == ST_IDLE);
  assign io_rsp_valid = (state_q == ST_RESP);
  assign io_rsp_rdata = rsp_rdata_q;
  assign io_rsp_error = rsp_error_q;
  assign io_mem_valid = mem_valid_q;
  assign io_mem_instr = mem_instr_q;
  assign io_mem_wstrb = mem_wstrb_q;
  assign io_mem_wdata = mem_wdata_q;
  assign io_mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: directed requests, a wait-state
// responder, a transaction-level expectation model and a per-cycle compare.
module tb_mem_initiator;

  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
  localparam int STALL      = 3;
`else
  localparam bit TIMEOUT_ON = 1'b0;
  localparam int STALL      = 5;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        io_req_valid, io_req_ready, io_req_instr, io_req_write, io_req_unsigned;
  logic [1:0]  io_req_size;
  logic [15:0] io_req_addr;
  logic [31:0] io_req_wdata;
  logic        io_rsp_valid, io_rsp_error;
  logic [31:0] io_rsp_rdata;
  logic        io_mem_valid, io_mem_instr, io_mem_ready;
  logic [3:0]  io_mem_wstrb;
  logic [31:0] io_mem_wdata, io_mem_rdata;
  logic [15:0] io_mem_addr;

  mem_initiator #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_instr(io_req_instr), .io_req_write(io_req_write),
    .io_req_size(io_req_size), .io_req_unsigned(io_req_unsigned),
    .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata),
    .io_rsp_valid(io_rsp_valid), .io_rsp_rdata(io_rsp_rdata), .io_rsp_error(io_rsp_error),
    .io_mem_valid(io_mem_valid), .io_mem_instr(io_mem_instr), .io_mem_wstrb(io_mem_wstrb),
    .io_mem_wdata(io_mem_wdata), .io_mem_addr(io_mem_addr),
    .io_mem_rdata(io_mem_rdata), .io_mem_ready(io_mem_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- expectation model ----------------
  function automatic int sz_bytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_wstrb(input bit wr, input logic [1:0] s, input logic [15:0] a);
    int n;
    logic [7:0] m;
    if (!wr) return 4'h0;
    n = sz_bytes(s);
    m = 8'(((1 << n) - 1) << (a % 4));
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] s);
    int n;
    logic [63:0] lane, r;
    n = sz_bytes(s);
    lane = {32'd0, wd} & ((64'd1 << (8 * n)) - 1);
    r = 64'd0;
    for (int i = 0; i < 4 / n; i++) r = r | (lane << (8 * n * i));
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_rdata(input bit ins, input bit wr, input logic [1:0] s,
                                          input bit uns, input logic [15:0] a, input logic [31:0] rd);
    int n;
    logic [63:0] v;
    if (wr) return 32'h0;
    if (ins) return rd;
    n = sz_bytes(s);
    v = ({32'd0, rd} >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
    if (!uns && n < 4 && v[8 * n - 1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  bit          active = 0, e_mis, e_write, e_instr, e_err;
  int          acc_cyc, rsp_cyc;
  logic [15:0] e_addr;
  logic [3:0]  e_wstrb;
  logic [31:0] e_wdata, e_rdata;

  // responder control
  int          rsp_waits = 0;
  logic [31:0] rsp_word  = 0;
  bit          noise     = 0;

  // observations of the DUT, for literal checks
  bit          chk_en = 0, mem_seen;
  int          rsp_seen_cyc;
  logic [31:0] last_rsp_rdata, last_mem_wdata;
  logic        last_rsp_err, last_mem_instr;
  logic [3:0]  last_mem_wstrb;
  logic [15:0] last_mem_addr;

  // Responder: ready after rsp_waits cycles of valid; optional stray ready while idle.
  initial begin : responder
    int seen;
    seen = 0;
    io_mem_ready = 1'b0;
    io_mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (io_mem_valid) begin
        if (seen >= rsp_waits) begin
          io_mem_ready = 1'b1; io_mem_rdata = rsp_word;
        end else begin
          io_mem_ready = 1'b0; io_mem_rdata = ~rsp_word;
        end
        seen++;
      end else begin
        seen = 0;
        io_mem_ready = noise;
        io_mem_rdata = 32'hA5A5_5A5A;
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the transaction model.
  always @(negedge clk) begin : compare
    bit busy, mv, rv;
    if (chk_en) begin
      busy = active && cyc >= acc_cyc && cyc <= rsp_cyc;
      mv   = active && !e_mis && cyc >= acc_cyc && cyc < rsp_cyc;
      rv   = active && cyc == rsp_cyc;
      check("req_ready", 32'(io_req_ready), 32'(!busy));
      check("mem_valid", 32'(io_mem_valid), 32'(mv));
      if (mv) begin
        check("mem_addr",  32'(io_mem_addr),  32'(e_addr));
        check("mem_instr", 32'(io_mem_instr), 32'(e_instr));
        check("mem_wstrb", 32'(io_mem_wstrb), 32'(e_wstrb));
        if (e_write) check("mem_wdata", io_mem_wdata, e_wdata);
      end
      check("rsp_valid", 32'(io_rsp_valid), 32'(rv));
      if (rv) begin
        check("rsp_rdata", io_rsp_rdata, e_rdata);
        check("rsp_error", 32'(io_rsp_error), 32'(e_err));
      end
    end
    if (io_mem_valid === 1'b1) begin
      mem_seen       = 1;
      last_mem_addr  = io_mem_addr;
      last_mem_instr = io_mem_instr;
      last_mem_wstrb = io_mem_wstrb;
      last_mem_wdata = io_mem_wdata;
    end
    if (io_rsp_valid === 1'b1) begin
      rsp_seen_cyc   = cyc;
      last_rsp_rdata = io_rsp_rdata;
      last_rsp_err   = io_rsp_error;
    end
  end

  // Present one request, load the model, and drop valid after the accept edge.
  task automatic issue(input bit ins, input bit wr, input logic [1:0] s, input bit uns,
                       input logic [15:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int waits);
    @(posedge clk); #1;
    io_req_valid = 1; io_req_instr = ins; io_req_write = wr; io_req_size = s;
    io_req_unsigned = uns; io_req_addr = a; io_req_wdata = wd;
    rsp_waits = waits; rsp_word = rd; mem_seen = 0; rsp_seen_cyc = -1;
    e_mis   = (a % sz_bytes(s)) != 0;
    e_addr  = a & 16'hFFFC;
    e_instr = ins; e_write = wr;
    e_wstrb = m_wstrb(wr, s, a);
    e_wdata = m_wdata(wd, s);
    acc_cyc = cyc + 1;
    if (e_mis) begin
      rsp_cyc = acc_cyc; e_err = 1; e_rdata = 0;
    end else if (TIMEOUT_ON && waits >= TMO) begin
      rsp_cyc = acc_cyc + TMO; e_err = 1; e_rdata = 0;
    end else begin
      rsp_cyc = acc_cyc + 1 + waits; e_err = 0; e_rdata = m_rdata(ins, wr, s, uns, a, rd);
    end
    active = 1;
    @(posedge clk); #1;
    io_req_valid = 0;
  endtask

  task automatic txn(input bit ins, input bit wr, input logic [1:0] s, input bit uns,
                     input logic [15:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int waits);
    issue(ins, wr, s, uns, a, wd, rd, waits);
    while (cyc <= rsp_cyc) begin
      @(posedge clk); #1;
    end
    active = 0;
  endtask

  // Latency counted as cycles from the accept cycle up to the response cycle.
  function automatic int lat();
    return rsp_seen_cyc - acc_cyc + 1;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    reset = 1; io_req_valid = 0; io_req_instr = 0; io_req_write = 0;
    io_req_size = 0; io_req_unsigned = 0; io_req_addr = 0; io_req_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(io_req_ready), 32'h1);
    check("rst_rsp_valid", 32'(io_rsp_valid), 32'h0);
    check("rst_rsp_rdata", io_rsp_rdata, 32'h0);
    check("rst_rsp_error", 32'(io_rsp_error), 32'h0);
    check("rst_mem_valid", 32'(io_mem_valid), 32'h0);
    check("rst_mem_instr", 32'(io_mem_instr), 32'h0);
    check("rst_mem_wstrb", 32'(io_mem_wstrb), 32'h0);
    check("rst_mem_wdata", io_mem_wdata, 32'h0);
    check("rst_mem_addr",  32'(io_mem_addr), 32'h0);
    reset = 0;
    chk_en = 1;

    // Word fetch, zero-wait responder.
    txn(1, 0, 2'd2, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);
    check("lit_fetch_rdata", last_rsp_rdata, 32'hDEADBEEF);
    check("lit_fetch_addr",  32'(last_mem_addr), 32'h0010);
    check("lit_fetch_instr", 32'(last_mem_instr), 32'h1);
    check("lit_fetch_wstrb", 32'(last_mem_wstrb), 32'h0);
    check("lit_fetch_lat",   32'(lat()), 32'd2);

    // Byte loads from the top lane, signed then unsigned.
    txn(0, 0, 2'd0, 0, 16'h0013, 32'h0, 32'h80AABBCC, 0);
    check("lit_lb_addr",  32'(last_mem_addr), 32'h0010);
    check("lit_lb_rdata", last_rsp_rdata, 32'hFFFFFF80);
    txn(0, 0, 2'd0, 1, 16'h0013, 32'h0, 32'h80AABBCC, 0);
    check("lit_lbu_rdata", last_rsp_rdata, 32'h00000080);

    // Half store to the upper half.
    txn(0, 1, 2'd1, 0, 16'h0022, 32'h1234ABCD, 32'h0, 0);
    check("lit_sh_wstrb", 32'(last_mem_wstrb), 32'hC);
    check("lit_sh_wdata", last_mem_wdata, 32'hABCDABCD);
    check("lit_sh_rdata", last_rsp_rdata, 32'h0);

    // Misaligned word load never reaches the bus.
    txn(0, 0, 2'd2, 0, 16'h0006, 32'h0, 32'h12345678, 0);
    check("lit_mis_bus", 32'(mem_seen), 32'h0);
    check("lit_mis_err", 32'(last_rsp_err), 32'h1);
    check("lit_mis_lat", 32'(lat()), 32'd1);

    // Wait states: outputs held, response one cycle after ready.
    txn(0, 0, 2'd2, 0, 16'h0040, 32'h0, 32'h11223344, STALL);
    check("lit_stall_rdata", last_rsp_rdata, 32'h11223344);
    check("lit_stall_lat",   32'(lat()), 32'(2 + STALL));

    // Byte store with stray ready pulses while idle.
    noise = 1;
    txn(0, 1, 2'd0, 0, 16'h0031, 32'h0000005A, 32'h0, 1);
    check("lit_sb_wstrb", 32'(last_mem_wstrb), 32'h2);
    check("lit_sb_wdata", last_mem_wdata, 32'h5A5A5A5A);
    noise = 0;

    // Half loads from the upper half, signed and unsigned.
    txn(0, 0, 2'd1, 0, 16'h0102, 32'h0, 32'h80011234, 0);
    check("lit_lh_rdata", last_rsp_rdata, 32'hFFFF8001);
    txn(0, 0, 2'd1, 1, 16'h0102, 32'h0, 32'h80011234, 2);
    check("lit_lhu_rdata", last_rsp_rdata, 32'h00008001);

    // Misaligned half, size 3 store treated as word, positive byte load.
    txn(0, 0, 2'd1, 0, 16'h0005, 32'h0, 32'h0, 0);
    check("lit_mis_half_err", 32'(last_rsp_err), 32'h1);
    txn(0, 1, 2'd3, 0, 16'h0104, 32'hCAFEF00D, 32'h0, 0);
    check("lit_sz3_wstrb", 32'(last_mem_wstrb), 32'hF);
    check("lit_sz3_wdata", last_mem_wdata, 32'hCAFEF00D);
    txn(0, 0, 2'd0, 0, 16'h0200, 32'h0, 32'h0000007F, 0);
    check("lit_lb_pos", last_rsp_rdata, 32'h0000007F);

    // Reset while waiting on the bus: request is dropped with no response.
    issue(0, 0, 2'd2, 0, 16'h0080, 32'h0, 32'h0BADF00D, 20);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    active = 0;
    check("lit_rst_mem_valid", 32'(io_mem_valid), 32'h0);
    check("lit_rst_req_ready", 32'(io_req_ready), 32'h1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("lit_rst_no_rsp", 32'(rsp_seen_cyc), 32'hFFFFFFFF);

    // Recovery after reset.
    txn(0, 0, 2'd2, 0, 16'h0008, 32'h0, 32'h13572468, 1);
    check("lit_after_rst", last_rsp_rdata, 32'h13572468);

`ifdef MEM_TIMEOUT_EN
    // Responder never answers: error after TMO bus cycles.
    txn(0, 0, 2'd2, 0, 16'h0090, 32'h0, 32'h55555555, 1000);
    check("lit_tmo_err",   32'(last_rsp_err), 32'h1);
    check("lit_tmo_rdata", last_rsp_rdata, 32'h0);
    check("lit_tmo_lat",   32'(lat()), 32'(1 + TMO));
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
